mips_cpu_regfile_arbiter: RTL and testbench

MIPS_CPU_REGFILE_ARBITER -- requirements
Module: mips_cpu_regfile_arbiter

---
 rtl/mips_cpu_regfile_arbiter.sv | 113 +++++++++++
 tb/tb_mips_cpu_regfile_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU/link and load-return writebacks,
// with a pending-load scoreboard that blocks WAW-hazard ALU writes and stalls decode.
module mips_cpu_regfile_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_req_i,
    input  logic [4:0]  alu_reg_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ack_o,
    input  logic        mem_req_i,
    input  logic [4:0]  mem_reg_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_or_i,
    output logic        mem_ack_o,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_reg_i,
    input  logic [4:0]  rd1_reg_i,
    input  logic [4:0]  rd2_reg_i,
    output logic        stall_o,
    output logic        write_enable_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] write_data_o,
    output logic        orwrite_o,
    output logic [31:0] pending_o
);

    typedef enum logic {GrantAlu, GrantMem} grant_e;

    grant_e      last_q, last_d;
    logic [31:0] pending_q, pending_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wor_q, wor_d;

    logic alu_elig;
    logic alu_gnt;
    logic mem_gnt;

    // pending_q[0] is held at zero, so register 0 never blocks or stalls.
    assign alu_elig = alu_req_i & ~pending_q[alu_reg_i];

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            if (alu_elig && mem_req_i) begin
                mem_gnt = (last_q == GrantAlu);
                alu_gnt = (last_q == GrantMem);
            end else begin
                alu_gnt = alu_elig;
                mem_gnt = mem_req_i;
            end
        end
    end

    assign alu_ack_o = alu_gnt;
    assign mem_ack_o = mem_gnt;
    assign stall_o   = pending_q[rd1_reg_i] | pending_q[rd2_reg_i];

    always_comb begin
        last_d    = last_q;
        pending_d = pending_q;
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        wor_d     = wor_q;
        if (mem_gnt) begin
            last_d               = GrantMem;
            pending_d[mem_reg_i] = 1'b0;
            we_d                 = (mem_reg_i != 5'd0);
            wreg_d               = mem_reg_i;
            wdata_d              = mem_data_i;
            wor_d                = mem_or_i;
        end else if (alu_gnt) begin
            last_d  = GrantAlu;
            we_d    = (alu_reg_i != 5'd0);
            wreg_d  = alu_reg_i;
            wdata_d = alu_data_i;
            wor_d   = 1'b0;
        end
        // Set after clear so a same-cycle issue and return leaves the bit set.
        if (ld_issue_i) begin
            pending_d[ld_reg_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= GrantAlu;
            pending_q <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            wor_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            wor_q     <= wor_d;
        end
    end

    assign write_enable_o = we_q;
    assign write_reg_o    = wreg_q;
    assign write_data_o   = wdata_q;
    assign orwrite_o      = wor_q;
    assign pending_o      = pending_q;

endmodule

// File: tb/tb_mips_cpu_regfile_arbiter.sv
// Scoreboard bench: a transaction-level reference model predicts grants and write-port state;
// a monitor compares the registered outputs each cycle against queued expectations.
module tb_mips_cpu_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_req, alu_ack, mem_req, mem_ack, mem_or, ld_issue, stall;
    logic [4:0]  alu_reg, mem_reg, ld_reg, rd1_reg, rd2_reg, write_reg;
    logic [31:0] alu_data, mem_data, write_data, pending;
    logic        write_enable, orwrite;

    always #5 clk = ~clk;

    mips_cpu_regfile_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_req_i     (alu_req),
        .alu_reg_i     (alu_reg),
        .alu_data_i    (alu_data),
        .alu_ack_o     (alu_ack),
        .mem_req_i     (mem_req),
        .mem_reg_i     (mem_reg),
        .mem_data_i    (mem_data),
        .mem_or_i      (mem_or),
        .mem_ack_o     (mem_ack),
        .ld_issue_i    (ld_issue),
        .ld_reg_i      (ld_reg),
        .rd1_reg_i     (rd1_reg),
        .rd2_reg_i     (rd2_reg),
        .stall_o       (stall),
        .write_enable_o(write_enable),
        .write_reg_o   (write_reg),
        .write_data_o  (write_data),
        .orwrite_o     (orwrite),
        .pending_o     (pending)
    );

    typedef struct packed {
        logic        we;
        logic        known;
        logic [4:0]  r;
        logic [31:0] d;
        logic        o;
        logic [31:0] pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state: set of outstanding loads, who was granted last, write-port image.
    bit          m_pend[32];
    bit          m_mem_last;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        m_wo;
    bit          m_known;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Called just after a falling edge with inputs already applied; returns at the next one.
    task automatic step(output bit ga, output bit gm);
        bit   blocked, exp_stall;
        exp_t e;
        #1;
        ga = 0;
        gm = 0;
        if (!reset) begin
            blocked = alu_req && alu_reg != 0 && m_pend[alu_reg];
            if (alu_req && !blocked && mem_req) begin
                gm = !m_mem_last;
                ga = m_mem_last;
            end else begin
                ga = alu_req && !blocked;
                gm = mem_req;
            end
        end
        exp_stall = (rd1_reg != 0 && m_pend[rd1_reg]) || (rd2_reg != 0 && m_pend[rd2_reg]);
        chk("alu_ack", 64'(alu_ack), 64'(ga));
        chk("mem_ack", 64'(mem_ack), 64'(gm));
        chk("stall", 64'(stall), 64'(exp_stall));
        e.we = 0;
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_mem_last = 0;
            m_wr = 0; m_wd = 0; m_wo = 0; m_known = 1;
        end else begin
            if (gm) m_pend[mem_reg] = 0;
            if (ld_issue && ld_reg != 0) m_pend[ld_reg] = 1;
            if (ga || gm) m_mem_last = gm;
            if (ga) begin
                e.we = (alu_reg != 0);
                m_wr = alu_reg; m_wd = alu_data; m_wo = 0; m_known = e.we;
            end
            if (gm) begin
                e.we = (mem_reg != 0);
                m_wr = mem_reg; m_wd = mem_data; m_wo = mem_or; m_known = e.we;
            end
        end
        e.known = m_known;
        e.r = m_wr; e.d = m_wd; e.o = m_wo;
        e.pend = pend_vec();
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("write_enable", 64'(write_enable), 64'(e.we));
            chk("pending", 64'(pending), 64'(e.pend));
            if (e.known) begin
                chk("write_reg", 64'(write_reg), 64'(e.r));
                chk("write_data", 64'(write_data), 64'(e.d));
                chk("orwrite", 64'(orwrite), 64'(e.o));
            end
        end
    end

    task automatic idle();
        alu_req = 0; mem_req = 0; ld_issue = 0; mem_or = 0;
        rd1_reg = 0; rd2_reg = 0;
    endtask

    initial begin
        bit ga, gm;
        int n;
        reset = 1; idle();
        alu_reg = 0; alu_data = 0; mem_reg = 0; mem_data = 0; ld_reg = 0;
        @(negedge clk);
        step(ga, gm); step(ga, gm);
        reset = 0;

        // Single ALU write.
        alu_req = 1; alu_reg = 5; alu_data = 32'h1234;
        step(ga, gm); idle(); step(ga, gm);

        // Tie: memory first after an ALU grant, then alternate.
        alu_req = 1; alu_reg = 6; alu_data = 32'hA0A0_0006;
        mem_req = 1; mem_reg = 7; mem_data = 32'hB0B0_0007;
        for (int i = 0; i < 4; i++) step(ga, gm);
        idle(); step(ga, gm);

        // Partial-word load return with OR-merge.
        mem_req = 1; mem_reg = 3; mem_or = 1; mem_data = 32'hFF00;
        step(ga, gm); idle(); step(ga, gm);

        // WAW block and decode stall until the load to r8 returns.
        ld_issue = 1; ld_reg = 8;
        step(ga, gm);
        ld_issue = 0; alu_req = 1; alu_reg = 8; alu_data = 32'hCAFE; rd1_reg = 8;
        step(ga, gm); step(ga, gm);
        mem_req = 1; mem_reg = 8; mem_data = 32'h8888; mem_or = 0;
        step(ga, gm);
        mem_req = 0;
        n = 0;
        do begin step(ga, gm); n++; end while (!ga && n < 20);
        chk("alu_unblocked", 64'(ga), 64'd1);
        idle(); step(ga, gm);

        // Same-cycle issue and return: set wins. Then ALU write to r0.
        ld_issue = 1; ld_reg = 9; mem_req = 1; mem_reg = 9; mem_data = 32'h9;
        step(ga, gm); idle();
        alu_req = 1; alu_reg = 0; alu_data = 32'hDEAD; rd1_reg = 9;
        step(ga, gm); idle(); step(ga, gm);

        // Reset with loads outstanding and both requesters active.
        ld_issue = 1; ld_reg = 4; step(ga, gm);
        ld_reg = 8; step(ga, gm);
        ld_issue = 0; reset = 1;
        alu_req = 1; alu_reg = 1; alu_data = 32'h11;
        mem_req = 1; mem_reg = 2; mem_data = 32'h22;
        step(ga, gm);
        reset = 0; idle(); step(ga, gm);

        // Randomised traffic; requesters hold their request stable until acked.
        for (int c = 0; c < 600; c++) begin
            if (!alu_req && $urandom_range(0, 2) == 0) begin
                alu_req = 1; alu_reg = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req = 1; mem_reg = 5'($urandom_range(0, 7)); mem_data = $urandom;
                mem_or = 1'($urandom);
            end
            ld_issue = ($urandom_range(0, 3) == 0);
            ld_reg   = 5'($urandom_range(0, 7));
            rd1_reg  = 5'($urandom_range(0, 7));
            rd2_reg  = 5'($urandom_range(0, 7));
            reset    = ($urandom_range(0, 60) == 0);
            step(ga, gm);
            if (ga || reset) alu_req = 0;
            if (gm || reset) mem_req = 0;
            reset = 0;
        end
        idle(); step(ga, gm);
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
